// File: rtl/dm_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface dm_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_ctrl.sv
// Byte-addressable little-endian data memory with valid/ready handshake and LAT-cycle access.
// Optional macro DM_ALIGN_TRAP_EN: misaligned half/word accesses return an error instead of completing.
module dm_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LAT         = 1
) (
    input  logic clk,
    input  logic rst,
    dm_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH_BYTES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    logic [1:0]             state;
    req_t                   rq;
    logic [3:0]             cnt;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic [7:0]             mem [DEPTH_BYTES];
    logic [3:0][ADDR_W-1:0] idx;
    logic [3:0][7:0]        rb;
    logic [3:0]             lane_we;
    logic                   err;
    logic                   commit;
    logic [31:0]            ld;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    // Lane index wraps naturally because idx is exactly ADDR_W bits wide.
    always_comb begin
        err = (rq.size == 2'b11);
`ifdef DM_ALIGN_TRAP_EN
        if ((rq.size == 2'b01 && rq.addr[0]) || (rq.size == 2'b10 && rq.addr[1:0] != 2'b00))
            err = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin
            idx[i]     = rq.addr + ADDR_W'(i);
            rb[i]      = mem[idx[i]];
            lane_we[i] = rq.we && !err &&
                         (i == 0 || rq.size == 2'b10 || (rq.size == 2'b01 && i < 2));
        end
    end

    always_comb begin
        case (rq.size)
            2'b00:   ld = {{24{rb[0][7] & ~rq.uns}}, rb[0]};
            2'b01:   ld = {{16{rb[1][7] & ~rq.uns}}, rb[1], rb[0]};
            2'b10:   ld = rb;
            default: ld = 32'd0;
        endcase
    end

    assign commit = (state == S_ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            rq      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    rq.we    <= bus.req_we;
                    rq.size  <= bus.req_size;
                    rq.uns   <= bus.req_unsigned;
                    rq.addr  <= bus.req_addr[ADDR_W-1:0];
                    rq.wdata <= bus.req_wdata;
                    cnt      <= 4'(LAT - 1);
                    state    <= S_ACCESS;
                end
                S_ACCESS: if (cnt == 4'd0) begin
                    rdata_q <= (rq.we || err) ? 32'd0 : ld;
                    err_q   <= err;
                    state   <= S_RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_RESP: if (bus.rsp_ready) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory is deliberately outside reset; a commit during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            for (int i = 0; i < 4; i++)
                if (lane_we[i]) mem[idx[i]] <= rq.wdata[8*i +: 8];
        end
    end

    assign bus.req_ready = rst && (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised, byte-addressable, little-endian data memory for the MEM stage of the 5-stage MIPS core.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Uses a valid/ready request/response handshake and a configurable access latency, so the pipeline can stall on memory.
- Flags illegal accesses with an error response instead of silently corrupting memory.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, minimum 4.
- LAT, 1, cycles from request acceptance to response valid; minimum 1, maximum 15.
- ADDR_W, log2(DEPTH_BYTES), derived index width; must not be overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address; bits above ADDR_W-1 ignored (modulo DEPTH_BYTES).
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access rejected (reserved size or misaligned).

Behaviour:
- Reset (rst low at a rising edge): state IDLE, req_ready=0 for that cycle, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
- Reset does not clear memory contents.
- Reset mid-transaction aborts it; a store not yet committed is never written.
- State IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we/size/unsigned/addr/wdata and load the counter with LAT-1.
  - Go to ACCESS.
- State ACCESS:
  - req_ready=0; the counter decrements each cycle.
  - At the edge where the counter is 0, commit and go to RESP:
    - Store: write bytes.
    - Load: capture and extend data.
    - Then rsp_valid=1.
  - rsp_valid therefore rises exactly LAT cycles after the accept edge.
- State RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE with rsp_valid=0.
  - No request is accepted in the same cycle as the response handshake; back-to-back throughput is one transaction per LAT+2 cycles.
- Byte lanes (a = latched address mod DEPTH_BYTES):
  - byte: mem[a] = wdata[7:0].
  - half: mem[a]=wdata[7:0], mem[a+1]=wdata[15:8].
  - word: mem[a..a+3] = wdata[7:0..31:24].
  - Untouched bytes are preserved.
- Loads:
  - byte extends bit 7; half extends bit 15; word is unchanged.
  - Read data is taken after any same-edge store commit; a load following a store to the same address returns the new value.
- Error:
  - req_size=11 always gives rsp_err=1, no write, rsp_rdata=0.
  - Alignment handling is governed by the optional feature.
- Wrap-around: index arithmetic is modulo DEPTH_BYTES; an access at a = DEPTH_BYTES-1 (when permitted) wraps to byte 0.
- Request inputs are ignored while req_ready=0.

Optional Feature:
- Macro: DM_ALIGN_TRAP_EN.
- Defined:
  - Half with a[0]=1, or word with a[1:0]!=0, gives rsp_err=1.
  - No memory change; rsp_rdata=0.
  - Latency is unchanged.
- Undefined:
  - Misaligned accesses complete normally, byte-wise, little-endian, with modulo wrap; rsp_err=0.
  - rsp_err is only raised for reserved size.

Test Plan:
- Reset, LAT=1: after rst low for 2 cycles then high → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store word 0x8899AABB at addr 0x10, then load byte signed at 0x13 → rsp_rdata=0xFFFFFF88.
- Same memory, load half unsigned at 0x12 → 0x00008899.
- Store byte 0x55 at 0x11, load word at 0x10 → 0x889955BB.
- Timing:
  - LAT=3: accept at cycle 0 → rsp_valid at cycle 3.
  - Hold rsp_ready=0 for 4 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout.
  - Release → IDLE next cycle.
- Misaligned word store to 0x3FE, DEPTH_BYTES=1024:
  - With DM_ALIGN_TRAP_EN → rsp_err=1, memory unchanged.
  - Without → bytes 0x3FE, 0x3FF, 0x000, 0x001 written, rsp_err=0.
- Assert rst low during ACCESS of a store with LAT=4 → no write occurs, rsp_valid=0 after reset.
- req_size=11 → rsp_err=1, rsp_rdata=0.
